// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_if
//  Purpose  : Request/response handshake bundle for the iterative MUL/DIV unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iterative
//  Purpose  : Radix-2 iterative RV32M multiply/divide unit, valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iterative #(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 5,
  parameter int FAST_SPECIAL = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mdu_if.slave      bus
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic [TAG_W-1:0]   r_tag;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_spec;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_special;
  logic               r_ready;
  logic               r_valid;
  logic               r_busy;
  logic [XLEN-1:0]    r_result;

  // Operand decode on the request side
  logic            w_rs1_signed, w_rs2_signed, w_s1, w_s2;
  logic            w_is_div, w_div0, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;

  assign w_rs1_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                        (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
  assign w_rs2_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) ||
                        (bus.op_i == 3'b110);
  assign w_s1      = w_rs1_signed & bus.rs1_i[XLEN-1];
  assign w_s2      = w_rs2_signed & bus.rs2_i[XLEN-1];
  assign w_a_mag   = w_s1 ? -bus.rs1_i : bus.rs1_i;
  assign w_b_mag   = w_s2 ? -bus.rs2_i : bus.rs2_i;
  assign w_is_div  = bus.op_i[2];
  assign w_div0    = w_is_div && (bus.rs2_i == '0);
  assign w_ovf     = w_is_div && !bus.op_i[0] &&
                     (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_accept  = bus.valid_i && r_ready && !bus.flush_i;

  // RISC-V mandated results: x/0 -> q=-1, r=x ; MIN/-1 -> q=MIN, r=0
  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = bus.op_i[1] ? bus.rs1_i : '1;
    else if (w_ovf)
      w_spec_res = bus.op_i[1] ? '0 : bus.rs1_i;
  end

  // Iteration datapath
  logic [XLEN:0]     w_madd, w_shift, w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dsel, w_dres, w_fin;

  assign w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_prod  = r_neg ? -r_acc : r_acc;
  assign w_dsel  = r_op[1] ? r_rem : r_quo;
  assign w_dres  = r_neg ? -w_dsel : w_dsel;

  always_comb begin
    w_fin = '0;
    if (r_special)
      w_fin = r_spec;
    else if (r_op[2])
      w_fin = w_dres;
    else if (r_op[1:0] == 2'b00)
      w_fin = w_prod[XLEN-1:0];
    else
      w_fin = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_tag     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_spec    <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= '0;
    end else if (r_state != S_IDLE && bus.flush_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= bus.op_i;
            r_tag     <= bus.tag_i;
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_acc     <= {{XLEN{1'b0}}, w_b_mag};
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_neg     <= (bus.op_i[2] && bus.op_i[1]) ? w_s1 : (w_s1 ^ w_s2);
            r_special <= w_special;
            r_spec    <= w_spec_res;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            if ((FAST_SPECIAL != 0) && w_special) begin
              r_result <= w_spec_res;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            // Restoring step: keep the trial difference only when it did not borrow
            if (!w_diff[XLEN]) begin
              r_rem <= w_diff[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
          end else begin
            r_acc <= {w_madd, r_acc[XLEN-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN-1))
            r_state <= S_FIN;
        end
        S_FIN: begin
          r_result <= w_fin;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (bus.ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.valid_o  = r_valid;
  assign bus.busy_o   = r_busy;
  assign bus.result_o = r_result;
  assign bus.tag_o    = r_tag;
endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iterative
//  Purpose  : Directed self-checking bench for mdu_iterative (XLEN=32, fast specials).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if #(.XLEN(32), .TAG_W(5)) bus ();

  mdu_iterative #(.XLEN(32), .TAG_W(5), .FAST_SPECIAL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request; returns at the negedge of cycle 1 with operands scrambled
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    int g = 0;
    while (!bus.ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.tag_i   = tag;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.op_i    = ~op;
    bus.rs1_i   = ~a;
    bus.rs2_i   = 32'h5A5A_5A5A;
    bus.tag_i   = ~tag;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, a, b, tag);
    wait_valid(lat);
    check({name, " result"}, bus.result_o, exp);
    check({name, " tag"}, 32'(bus.tag_o), 32'(tag));
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    handoff();
    check({name, " ready after handoff"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    int lat;
    bit seen;
    bus.valid_i = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.tag_i   = '0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset ready_o", 32'(bus.ready_o), 32'd1);
    check("reset valid_o", 32'(bus.valid_o), 32'd0);
    check("reset busy_o", 32'(bus.busy_o), 32'd0);
    check("reset result_o", bus.result_o, 32'd0);
    check("reset tag_o", 32'(bus.tag_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply group
    run_op("MUL 7*-3",        3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 34);
    run_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 34);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 34);
    run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 34);
    run_op("MULH -3*7",       3'b001, 32'hFFFF_FFFD, 32'd7,         5'd7,  32'hFFFF_FFFF, 34);

    // Special divide cases on the single-cycle path
    run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1);
    run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 1);
    run_op("DIVU 20/0",       3'b101, 32'd20,        32'd0,         5'd10, 32'hFFFF_FFFF, 1);
    run_op("REMU 20/0",       3'b111, 32'd20,        32'd0,         5'd11, 32'd20,        1);
    run_op("DIV -7/0",        3'b100, 32'hFFFF_FFF9, 32'd0,         5'd12, 32'hFFFF_FFFF, 1);
    run_op("REM -7/0",        3'b110, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFF9, 1);

    // Regular divides
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD, 34);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF, 34);
    run_op("DIVU 100/7",      3'b101, 32'd100,       32'd7,         5'd16, 32'd14,        34);
    run_op("REMU 100/7",      3'b111, 32'd100,       32'd7,         5'd17, 32'd2,         34);
    run_op("DIV 7/-2",        3'b100, 32'd7,         32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD, 34);
    run_op("REM 7/-2",        3'b110, 32'd7,         32'hFFFF_FFFE, 5'd19, 32'd1,         34);

    // Backpressure: result and tag held while the consumer stalls
    start_op(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd9);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd34);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp result held", bus.result_o, 32'h2345_6780);
      check("bp tag held", 32'(bus.tag_o), 32'd9);
      check("bp ready_o low", 32'(bus.ready_o), 32'd0);
      check("bp valid_o high", 32'(bus.valid_o), 32'd1);
    end
    handoff();
    check("bp ready_o after", 32'(bus.ready_o), 32'd1);
    check("bp valid_o after", 32'(bus.valid_o), 32'd0);

    // Flush mid-CALC
    start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21);
    repeat (10) @(negedge clk);
    check("flush busy before", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush ready_o", 32'(bus.ready_o), 32'd1);
    check("flush busy_o", 32'(bus.busy_o), 32'd0);
    check("flush valid_o", 32'(bus.valid_o), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    check("flush no result", 32'(seen), 32'd0);

    // Flush in IDLE wins over a request
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = 3'b101;
    bus.rs1_i   = 32'd5;
    bus.rs2_i   = 32'd0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("idle flush busy_o", 32'(bus.busy_o), 32'd0);
    check("idle flush ready_o", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    check("idle flush valid_o", 32'(bus.valid_o), 32'd0);

    // Async reset mid-CALC, then a clean op
    start_op(3'b101, 32'd1000, 32'd3, 5'd22);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset ready_o", 32'(bus.ready_o), 32'd1);
    check("areset valid_o", 32'(bus.valid_o), 32'd0);
    check("areset busy_o", 32'(bus.busy_o), 32'd0);
    check("areset result_o", bus.result_o, 32'd0);
    check("areset tag_o", 32'(bus.tag_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post-reset DIVU", 3'b101, 32'd100, 32'd7, 5'd23, 32'd14, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
